// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM driving the lab datapath and ALU op interface
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             iord,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [4:0]       alu_op,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             exc,
  output logic [CNT_W-1:0] retired
);
  localparam logic [4:0] ALU_AND  = 5'b00111;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_XOR  = 5'b00010;
  localparam logic [4:0] ALU_NOR  = 5'b00011;
  localparam logic [4:0] ALU_LUI  = 5'b00100;
  localparam logic [4:0] ALU_ADD  = 5'b10000;
  localparam logic [4:0] ALU_ADDU = 5'b10001;
  localparam logic [4:0] ALU_SUB  = 5'b10010;
  localparam logic [4:0] ALU_SUBU = 5'b10011;
  localparam logic [4:0] ALU_SLT  = 5'b10100;
  localparam logic [4:0] ALU_SLTU = 5'b10101;

  typedef enum logic [3:0] {
    FETCH, DECODE, RTYPE, IMMEX, RWB, IWB, MEMADR,
    MEMRD, MEMWB, MEMWR, BRANCH, JUMP, ILLEGAL
  } state_t;

  state_t     state, state_nx;
  logic       trap_chk, ext_q, r_ok, i_ok, i_zx, trap, retire;
  logic [4:0] alu_q, r_op, i_op;

  assign i_zx   = opcode[5:2] == 4'b0011 && opcode[1:0] != 2'b11;
  assign trap   = trap_chk && overflow;
  assign retire = ((state == RWB || state == IWB) && !trap) || state == MEMWB ||
                  (state == MEMWR && mem_ready) || state == BRANCH || state == JUMP;

  // R-type funct to ALU op; unknown functs are flagged for the illegal trap
  always_comb begin
    r_op = 5'b0;
    r_ok = 1'b1;
    case (funct)
      6'b100000: r_op = ALU_ADD;
      6'b100001: r_op = ALU_ADDU;
      6'b100010: r_op = ALU_SUB;
      6'b100011: r_op = ALU_SUBU;
      6'b100100: r_op = ALU_AND;
      6'b100101: r_op = ALU_OR;
      6'b100110: r_op = ALU_XOR;
      6'b100111: r_op = ALU_NOR;
      6'b101010: r_op = ALU_SLT;
      6'b101011: r_op = ALU_SLTU;
      default:   r_ok = 1'b0;
    endcase
  end

  // immediate-form opcode to ALU op; i_ok marks the opcodes that take the IMMEX path
  always_comb begin
    i_op = ALU_ADDU;
    i_ok = 1'b1;
    case (opcode)
      6'b001000: i_op = ALU_ADD;
      6'b001001: i_op = ALU_ADDU;
      6'b001100: i_op = ALU_AND;
      6'b001101: i_op = ALU_OR;
      6'b001110: i_op = ALU_XOR;
      6'b001010: i_op = ALU_SLT;
      6'b001011: i_op = ALU_SLTU;
      6'b001111: i_op = ALU_LUI;
      default:   i_ok = 1'b0;
    endcase
  end

  // state register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;

  // capture the execute-stage ALU setup so writeback holds it and knows whether to trap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_q    <= 5'b0;
      ext_q    <= 1'b0;
      trap_chk <= 1'b0;
    end else if (state == RTYPE) begin
      alu_q    <= r_op;
      ext_q    <= 1'b0;
      trap_chk <= funct == 6'b100000 || funct == 6'b100010;
    end else if (state == IMMEX) begin
      alu_q    <= i_op;
      ext_q    <= i_zx;
      trap_chk <= opcode == 6'b001000;
    end

  // retired-instruction counter, wraps freely
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);

  // next-state sequencing
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:  state_nx = mem_ready ? DECODE : FETCH;
      DECODE:
        case (opcode)
          6'b000000:            state_nx = RTYPE;
          6'b100011, 6'b101011: state_nx = MEMADR;
          6'b000100, 6'b000101: state_nx = BRANCH;
          6'b000010:            state_nx = JUMP;
          default:              state_nx = i_ok ? IMMEX : ILLEGAL;
        endcase
      RTYPE:  state_nx = r_ok ? RWB : ILLEGAL;
      IMMEX:  state_nx = IWB;
      MEMADR: state_nx = opcode[3] ? MEMWR : MEMRD;
      MEMRD:  state_nx = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_nx = mem_ready ? FETCH : MEMWR;
      default: state_nx = FETCH;
    endcase
  end

  // datapath strobes decoded from state, qualified by handshake and ALU flags
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_zero   = 1'b0;
    alu_op     = 5'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    exc        = 1'b0;
    case (state)
      FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALU_ADDU;
        ir_wr     = mem_ready;
        pc_wr     = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADDU;
      end
      RTYPE: begin
        alu_src_a = 1'b1;
        alu_op    = r_op;
      end
      IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = i_op;
        ext_zero  = i_zx;
      end
      RWB, IWB: begin
        alu_src_a = 1'b1;
        alu_src_b = state == IWB ? 2'd2 : 2'd0;
        alu_op    = alu_q;
        ext_zero  = ext_q;
        reg_wr    = !trap;
        reg_dst   = state == RWB;
        exc       = trap;
        pc_wr     = trap;
        pc_src    = trap ? 2'd3 : 2'd0;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = ALU_ADDU;
      end
      MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      MEMWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUBU;
        pc_src    = 2'd1;
        pc_wr     = opcode[0] ? !zero : zero;
      end
      JUMP: begin
        pc_wr  = 1'b1;
        pc_src = 2'd2;
      end
      ILLEGAL: begin
        exc    = 1'b1;
        pc_wr  = 1'b1;
        pc_src = 2'd3;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: instruction-level scoreboard bench for mc_ctrl with a memory handshake responder
module tb_mc_ctrl;
  localparam int W = 4;
  localparam logic [4:0] A_AND  = 5'b00111;
  localparam logic [4:0] A_OR   = 5'b00001;
  localparam logic [4:0] A_XOR  = 5'b00010;
  localparam logic [4:0] A_NOR  = 5'b00011;
  localparam logic [4:0] A_LUI  = 5'b00100;
  localparam logic [4:0] A_ADD  = 5'b10000;
  localparam logic [4:0] A_ADDU = 5'b10001;
  localparam logic [4:0] A_SUB  = 5'b10010;
  localparam logic [4:0] A_SUBU = 5'b10011;
  localparam logic [4:0] A_SLT  = 5'b10100;
  localparam logic [4:0] A_SLTU = 5'b10101;

  typedef struct {
    int         cycles;
    logic [4:0] alu_op;
    int         ext_zero;
    int         reg_wr_n;
    int         reg_dst;
    int         mem_to_reg;
    int         exc_n;
    int         mem_wr_seen;
    int         pc_wr_last;
    int         pc_src_last;
    int         delta;
  } rec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         z;
    int         ov;
    int         fw;
    int         mw;
    rec_t       e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, zero, overflow, mem_ready;
  logic [5:0]   opcode, funct;
  logic         mem_rd, mem_wr, iord, ir_wr, pc_wr, alu_src_a, ext_zero;
  logic         reg_wr, reg_dst, mem_to_reg, exc;
  logic [1:0]   pc_src, alu_src_b;
  logic [4:0]   alu_op;
  logic [W-1:0] retired;

  mc_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .iord(iord), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_op(alu_op), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .exc(exc), .retired(retired)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   rec_k = 0;
  rec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic score(input rec_t a);
    rec_t e;
    if (exp_q.size() == 0) begin
      chk("sb_pending", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("i%0d.cycles", rec_k), a.cycles, e.cycles);
    chk($sformatf("i%0d.alu_op", rec_k), a.alu_op, e.alu_op);
    chk($sformatf("i%0d.ext_zero", rec_k), a.ext_zero, e.ext_zero);
    chk($sformatf("i%0d.reg_wr", rec_k), a.reg_wr_n, e.reg_wr_n);
    chk($sformatf("i%0d.reg_dst", rec_k), a.reg_dst, e.reg_dst);
    chk($sformatf("i%0d.mem_to_reg", rec_k), a.mem_to_reg, e.mem_to_reg);
    chk($sformatf("i%0d.exc", rec_k), a.exc_n, e.exc_n);
    chk($sformatf("i%0d.mem_wr", rec_k), a.mem_wr_seen, e.mem_wr_seen);
    chk($sformatf("i%0d.pc_wr", rec_k), a.pc_wr_last, e.pc_wr_last);
    chk($sformatf("i%0d.pc_src", rec_k), a.pc_src_last, e.pc_src_last);
    chk($sformatf("i%0d.retired_delta", rec_k), a.delta, e.delta);
    rec_k++;
  endtask

  // monitor: splits the output stream into instructions at each fetch start
  rec_t         o;
  int           m_cyc = 0;
  int           m_nf = 0;
  logic         m_open = 1'b0;
  logic         m_pf = 1'b0;
  logic         m_cf;
  logic [W-1:0] m_r0, m_dl;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_open = 1'b0;
      m_pf   = 1'b0;
    end else begin
      m_cf = mem_rd && !iord && !mem_wr;
      if (m_cf && !m_pf) begin
        if (m_open) begin
          m_dl     = retired - m_r0;
          o.cycles = m_cyc;
          o.delta  = int'(m_dl);
          score(o);
        end
        m_open = 1'b1;
        m_r0   = retired;
        m_cyc  = 1;
        m_nf   = 0;
        o      = '{0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      end else if (m_open) begin
        m_cyc++;
        if (!m_cf) begin
          m_nf++;
          if (m_nf == 2) begin
            o.alu_op   = alu_op;
            o.ext_zero = int'(ext_zero);
          end
          if (reg_wr) begin
            o.reg_wr_n   = o.reg_wr_n + 1;
            o.reg_dst    = int'(reg_dst);
            o.mem_to_reg = int'(mem_to_reg);
          end
          if (exc) o.exc_n = o.exc_n + 1;
          if (mem_wr) o.mem_wr_seen = 1;
          o.pc_wr_last  = int'(pc_wr);
          o.pc_src_last = int'(pc_src);
        end
      end
      m_pf = m_cf;
    end
  end

  // driver state
  logic prev = 1'b0;
  logic start = 1'b0;
  logic waiting = 1'b0;
  int   cnt = 0;
  int   fw = 0;
  int   mw = 0;

  task automatic step();
    logic cur;
    @(posedge clk);
    #1;
    cur   = mem_rd && !iord && !mem_wr;
    start = cur && !prev;
    prev  = cur;
  endtask

  task automatic respond();
    if (waiting) chk("mem_hold", mem_rd | mem_wr, 1);
    waiting = 1'b0;
    if (mem_rd || mem_wr) begin
      if (cnt < (iord ? mw : fw)) begin
        mem_ready = 1'b0;
        cnt++;
        waiting = 1'b1;
      end else begin
        mem_ready = 1'b1;
        cnt = 0;
      end
    end else mem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input vec_t v);
    int c;
    opcode   = v.op;
    funct    = v.fn;
    zero     = v.z[0];
    overflow = v.ov[0];
    fw       = v.fw;
    mw       = v.mw;
    cnt      = 0;
    waiting  = 1'b0;
    exp_q.push_back(v.e);
    respond();
    c = 0;
    do begin
      step();
      if (!start) respond();
      c++;
    end while (!start && c < 64);
    if (!start) chk("run_timeout", c, 0);
  endtask

  task automatic sync_start();
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while (!start && c < 8);
    if (!start) chk("sync_timeout", c, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  vec_t tv[32];
  int   c;
  initial begin
    // {opcode, funct, zero, ovf, fetch wait, mem wait,
    //  {cycles, alu_op, ext_zero, reg_wr, reg_dst, mem_to_reg, exc, mem_wr, pc_wr, pc_src, retire}}
    tv[0]  = '{6'b000000, 6'b100001, 0, 1, 0, 0, '{4, A_ADDU, 0, 1, 1, 0, 0, 0, 0, 0, 1}};
    tv[1]  = '{6'b000010, 6'b000000, 0, 0, 1, 0, '{4, 5'd0, 0, 0, 0, 0, 0, 0, 1, 2, 1}};
    tv[2]  = '{6'b000000, 6'b100000, 0, 0, 0, 0, '{4, A_ADD, 0, 1, 1, 0, 0, 0, 0, 0, 1}};
    tv[3]  = '{6'b000000, 6'b100000, 0, 1, 0, 0, '{4, A_ADD, 0, 0, 0, 0, 1, 0, 1, 3, 0}};
    tv[4]  = '{6'b000000, 6'b100010, 0, 1, 0, 0, '{4, A_SUB, 0, 0, 0, 0, 1, 0, 1, 3, 0}};
    tv[5]  = '{6'b000000, 6'b100010, 1, 0, 0, 0, '{4, A_SUB, 0, 1, 1, 0, 0, 0, 0, 0, 1}};
    tv[6]  = '{6'b000000, 6'b100011, 0, 1, 0, 0, '{4, A_SUBU, 0, 1, 1, 0, 0, 0, 0, 0, 1}};
    tv[7]  = '{6'b000000, 6'b100100, 0, 0, 0, 0, '{4, A_AND, 0, 1, 1, 0, 0, 0, 0, 0, 1}};
    tv[8]  = '{6'b000000, 6'b100101, 0, 0, 0, 0, '{4, A_OR, 0, 1, 1, 0, 0, 0, 0, 0, 1}};
    tv[9]  = '{6'b000000, 6'b100110, 0, 0, 0, 0, '{4, A_XOR, 0, 1, 1, 0, 0, 0, 0, 0, 1}};
    tv[10] = '{6'b000000, 6'b100111, 0, 0, 0, 0, '{4, A_NOR, 0, 1, 1, 0, 0, 0, 0, 0, 1}};
    tv[11] = '{6'b000000, 6'b101010, 0, 0, 0, 0, '{4, A_SLT, 0, 1, 1, 0, 0, 0, 0, 0, 1}};
    tv[12] = '{6'b000000, 6'b101011, 0, 1, 0, 0, '{4, A_SLTU, 0, 1, 1, 0, 0, 0, 0, 0, 1}};
    tv[13] = '{6'b000000, 6'b000000, 0, 0, 0, 0, '{4, 5'd0, 0, 0, 0, 0, 1, 0, 1, 3, 0}};
    tv[14] = '{6'b001000, 6'b000000, 0, 1, 0, 0, '{4, A_ADD, 0, 0, 0, 0, 1, 0, 1, 3, 0}};
    tv[15] = '{6'b001000, 6'b111111, 0, 0, 0, 0, '{4, A_ADD, 0, 1, 0, 0, 0, 0, 0, 0, 1}};
    tv[16] = '{6'b001001, 6'b000000, 0, 1, 0, 0, '{4, A_ADDU, 0, 1, 0, 0, 0, 0, 0, 0, 1}};
    tv[17] = '{6'b001100, 6'b000000, 0, 0, 0, 0, '{4, A_AND, 1, 1, 0, 0, 0, 0, 0, 0, 1}};
    tv[18] = '{6'b001101, 6'b000000, 0, 0, 0, 0, '{4, A_OR, 1, 1, 0, 0, 0, 0, 0, 0, 1}};
    tv[19] = '{6'b001110, 6'b000000, 0, 0, 0, 0, '{4, A_XOR, 1, 1, 0, 0, 0, 0, 0, 0, 1}};
    tv[20] = '{6'b001010, 6'b000000, 0, 0, 0, 0, '{4, A_SLT, 0, 1, 0, 0, 0, 0, 0, 0, 1}};
    tv[21] = '{6'b001011, 6'b000000, 0, 0, 0, 0, '{4, A_SLTU, 0, 1, 0, 0, 0, 0, 0, 0, 1}};
    tv[22] = '{6'b001111, 6'b000000, 0, 0, 0, 0, '{4, A_LUI, 0, 1, 0, 0, 0, 0, 0, 0, 1}};
    tv[23] = '{6'b100011, 6'b000000, 0, 0, 3, 2, '{10, A_ADDU, 0, 1, 0, 1, 0, 0, 0, 0, 1}};
    tv[24] = '{6'b101011, 6'b000000, 0, 0, 0, 1, '{5, A_ADDU, 0, 0, 0, 0, 0, 1, 0, 0, 1}};
    tv[25] = '{6'b100011, 6'b000000, 0, 0, 0, 0, '{5, A_ADDU, 0, 1, 0, 1, 0, 0, 0, 0, 1}};
    tv[26] = '{6'b000100, 6'b000000, 1, 0, 0, 0, '{3, A_SUBU, 0, 0, 0, 0, 0, 0, 1, 1, 1}};
    tv[27] = '{6'b000100, 6'b000000, 0, 0, 0, 0, '{3, A_SUBU, 0, 0, 0, 0, 0, 0, 0, 1, 1}};
    tv[28] = '{6'b000101, 6'b000000, 1, 0, 0, 0, '{3, A_SUBU, 0, 0, 0, 0, 0, 0, 0, 1, 1}};
    tv[29] = '{6'b000101, 6'b000000, 0, 0, 0, 0, '{3, A_SUBU, 0, 0, 0, 0, 0, 0, 1, 1, 1}};
    tv[30] = '{6'b111111, 6'b000000, 0, 0, 0, 0, '{3, 5'd0, 0, 0, 0, 0, 1, 0, 1, 3, 0}};
    tv[31] = '{6'b101011, 6'b000000, 0, 0, 2, 0, '{6, A_ADDU, 0, 0, 0, 0, 0, 1, 0, 0, 1}};
    opcode    = 6'b0;
    funct     = 6'b0;
    zero      = 1'b0;
    overflow  = 1'b0;
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    chk("rst_mem_rd", mem_rd, 1);
    chk("rst_iord", iord, 0);
    chk("rst_alu_src_b", alu_src_b, 1);
    chk("rst_alu_op", alu_op, A_ADDU);
    chk("rst_pc_wr", pc_wr, 0);
    chk("rst_exc", exc, 0);
    chk("rst_retired", retired, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    sync_start();
    run(tv[0]);
    run(tv[1]);
    chk("pre_abort_retired", retired, 2);
    opcode    = 6'b101011;
    funct     = 6'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    c = 0;
    while (!mem_wr && c < 8) begin
      step();
      c++;
    end
    chk("abort_reach_memwr", mem_wr, 1);
    step();
    step();
    chk("abort_memwr_held", mem_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_wr", mem_wr, 0);
    chk("abort_pc_wr", pc_wr, 0);
    chk("abort_reg_wr", reg_wr, 0);
    chk("abort_fetch_rd", mem_rd, 1);
    chk("abort_fetch_iord", iord, 0);
    chk("abort_retired", retired, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    prev    = 1'b0;
    waiting = 1'b0;
    chk("release_retired", retired, 0);
    sync_start();
    for (int i = 0; i < 15; i++) run(tv[0]);
    chk("wrap_full", retired, 4'hF);
    run(tv[1]);
    chk("wrap_zero", retired, 0);
    for (int i = 0; i < 32; i++) run(tv[i]);
    @(negedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
